// File: rtl/ysyx_25040111_axi_arbiter_pkg.sv
// Shared encodings for the IFU/LSU AXI arbiter: FSM states, master indices, response codes.
package ysyx_25040111_axi_arbiter_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2} arb_state_e;
   localparam logic       M_IFU     = 1'b0;
   localparam logic       M_LSU     = 1'b1;
   localparam logic [1:0] RESP_OKAY = 2'b00;
endpackage

// File: rtl/ysyx_25040111_axi_arbiter_pick.sv
// Two-requester picker. YSYX_25040111_ARB_RR_EN selects round-robin; otherwise LSU has fixed priority.
module ysyx_25040111_arb_pick
   import ysyx_25040111_axi_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic       win
);
`ifdef YSYX_25040111_ARB_RR_EN
   always_comb begin
      if (req == 2'b11)     win = ~last;
      else if (req[M_LSU])  win = M_LSU;
      else if (req[M_IFU])  win = M_IFU;
      else                  win = last;
   end
`else
   // with no request the result is ignored; echoing last keeps the input meaningful
   always_comb begin
      if (req[M_LSU])       win = M_LSU;
      else if (req[M_IFU])  win = M_IFU;
      else                  win = last;
   end
`endif
endmodule

// File: rtl/ysyx_25040111_axi_arbiter.sv
// Shares io_master between IFU (m0) and LSU (m1), one transaction at a time.
// Tie-break policy set by YSYX_25040111_ARB_RR_EN (round-robin) or fixed LSU priority when undefined.
module ysyx_25040111_axi_arbiter
   import ysyx_25040111_axi_arbiter_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int STRB_W = DATA_W/8
) (
   input  logic clk, rst,
   input  logic m0_arvalid, input logic [ADDR_W-1:0] m0_araddr, input logic [3:0] m0_arid,
   input  logic [7:0] m0_arlen, input logic [2:0] m0_arsize, input logic [1:0] m0_arburst,
   output logic m0_arready,
   output logic [DATA_W-1:0] m0_rdata, output logic [1:0] m0_rresp, output logic m0_rlast,
   output logic [3:0] m0_rid, output logic m0_rvalid, input logic m0_rready,
   input  logic m0_awvalid, input logic [ADDR_W-1:0] m0_awaddr, input logic [3:0] m0_awid,
   input  logic [7:0] m0_awlen, input logic [2:0] m0_awsize, input logic [1:0] m0_awburst,
   output logic m0_awready,
   input  logic m0_wvalid, input logic [DATA_W-1:0] m0_wdata, input logic [STRB_W-1:0] m0_wstrb,
   input  logic m0_wlast, output logic m0_wready,
   output logic m0_bvalid, output logic [1:0] m0_bresp, output logic [3:0] m0_bid, input logic m0_bready,
   input  logic m1_arvalid, input logic [ADDR_W-1:0] m1_araddr, input logic [3:0] m1_arid,
   input  logic [7:0] m1_arlen, input logic [2:0] m1_arsize, input logic [1:0] m1_arburst,
   output logic m1_arready,
   output logic [DATA_W-1:0] m1_rdata, output logic [1:0] m1_rresp, output logic m1_rlast,
   output logic [3:0] m1_rid, output logic m1_rvalid, input logic m1_rready,
   input  logic m1_awvalid, input logic [ADDR_W-1:0] m1_awaddr, input logic [3:0] m1_awid,
   input  logic [7:0] m1_awlen, input logic [2:0] m1_awsize, input logic [1:0] m1_awburst,
   output logic m1_awready,
   input  logic m1_wvalid, input logic [DATA_W-1:0] m1_wdata, input logic [STRB_W-1:0] m1_wstrb,
   input  logic m1_wlast, output logic m1_wready,
   output logic m1_bvalid, output logic [1:0] m1_bresp, output logic [3:0] m1_bid, input logic m1_bready,
   output logic s_arvalid, output logic [ADDR_W-1:0] s_araddr, output logic [3:0] s_arid,
   output logic [7:0] s_arlen, output logic [2:0] s_arsize, output logic [1:0] s_arburst,
   input  logic s_arready,
   input  logic [DATA_W-1:0] s_rdata, input logic [1:0] s_rresp, input logic s_rlast,
   input  logic [3:0] s_rid, input logic s_rvalid, output logic s_rready,
   output logic s_awvalid, output logic [ADDR_W-1:0] s_awaddr, output logic [3:0] s_awid,
   output logic [7:0] s_awlen, output logic [2:0] s_awsize, output logic [1:0] s_awburst,
   input  logic s_awready,
   output logic s_wvalid, output logic [DATA_W-1:0] s_wdata, output logic [STRB_W-1:0] s_wstrb,
   output logic s_wlast, input logic s_wready,
   input  logic s_bvalid, input logic [1:0] s_bresp, input logic [3:0] s_bid, output logic s_bready
);
   logic [1:0]             m_arvalid, m_awvalid, m_wvalid, m_wlast, m_rready, m_bready;
   logic [1:0][ADDR_W-1:0] m_araddr, m_awaddr;
   logic [1:0][3:0]        m_arid, m_awid;
   logic [1:0][7:0]        m_arlen, m_awlen;
   logic [1:0][2:0]        m_arsize, m_awsize;
   logic [1:0][1:0]        m_arburst, m_awburst;
   logic [1:0][DATA_W-1:0] m_wdata;
   logic [1:0][STRB_W-1:0] m_wstrb;

   assign m_arvalid = {m1_arvalid, m0_arvalid};  assign m_araddr  = {m1_araddr, m0_araddr};
   assign m_arid    = {m1_arid, m0_arid};        assign m_arlen   = {m1_arlen, m0_arlen};
   assign m_arsize  = {m1_arsize, m0_arsize};    assign m_arburst = {m1_arburst, m0_arburst};
   assign m_awvalid = {m1_awvalid, m0_awvalid};  assign m_awaddr  = {m1_awaddr, m0_awaddr};
   assign m_awid    = {m1_awid, m0_awid};        assign m_awlen   = {m1_awlen, m0_awlen};
   assign m_awsize  = {m1_awsize, m0_awsize};    assign m_awburst = {m1_awburst, m0_awburst};
   assign m_wvalid  = {m1_wvalid, m0_wvalid};    assign m_wdata   = {m1_wdata, m0_wdata};
   assign m_wstrb   = {m1_wstrb, m0_wstrb};      assign m_wlast   = {m1_wlast, m0_wlast};
   assign m_rready  = {m1_rready, m0_rready};    assign m_bready  = {m1_bready, m0_bready};

   logic [1:0]             m_arready, m_rvalid, m_rlast, m_awready, m_wready, m_bvalid;
   logic [1:0][DATA_W-1:0] m_rdata;
   logic [1:0][1:0]        m_rresp, m_bresp;
   logic [1:0][3:0]        m_rid, m_bid;

   assign m0_arready = m_arready[0]; assign m1_arready = m_arready[1];
   assign m0_rvalid  = m_rvalid[0];  assign m1_rvalid  = m_rvalid[1];
   assign m0_rdata   = m_rdata[0];   assign m1_rdata   = m_rdata[1];
   assign m0_rresp   = m_rresp[0];   assign m1_rresp   = m_rresp[1];
   assign m0_rlast   = m_rlast[0];   assign m1_rlast   = m_rlast[1];
   assign m0_rid     = m_rid[0];     assign m1_rid     = m_rid[1];
   assign m0_awready = m_awready[0]; assign m1_awready = m_awready[1];
   assign m0_wready  = m_wready[0];  assign m1_wready  = m_wready[1];
   assign m0_bvalid  = m_bvalid[0];  assign m1_bvalid  = m_bvalid[1];
   assign m0_bresp   = m_bresp[0];   assign m1_bresp   = m_bresp[1];
   assign m0_bid     = m_bid[0];     assign m1_bid     = m_bid[1];

   arb_state_e state, state_d;
   logic       gnt, gnt_d, ar_done, ar_done_d, win, pick_last;
   logic [1:0] req;

   assign req = m_arvalid | m_awvalid;

   ysyx_25040111_arb_pick u_pick (.req(req), .last(pick_last), .win(win));

`ifdef YSYX_25040111_ARB_RR_EN
   logic last;
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                            last <= 1'b1;
      else if (state == IDLE && |req)     last <= win;
   end
   assign pick_last = last;
`else
   assign pick_last = 1'b1;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         gnt     <= M_IFU;
         ar_done <= 1'b0;
      end else begin
         state   <= state_d;
         gnt     <= gnt_d;
         ar_done <= ar_done_d;
      end
   end

   always_comb begin
      state_d   = state;
      gnt_d     = gnt;
      ar_done_d = ar_done;
      case (state)
         IDLE: begin
            ar_done_d = 1'b0;
            if (|req) begin
               gnt_d   = win;
               state_d = m_arvalid[win] ? RD : WR;
            end
         end
         RD: begin
            // a master may re-raise arvalid mid-burst; only the first AR belongs to this grant
            if (s_arvalid && s_arready) ar_done_d = 1'b1;
            if (s_rvalid && m_rready[gnt] && s_rlast) state_d = IDLE;
         end
         WR:      if (s_bvalid && m_bready[gnt]) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      s_arvalid = 1'b0; s_araddr = '0; s_arid = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0;
      s_awvalid = 1'b0; s_awaddr = '0; s_awid = '0; s_awlen = '0; s_awsize = '0; s_awburst = '0;
      s_wvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0;
      s_rready = 1'b0; s_bready = 1'b0;
      m_arready = '0; m_rvalid = '0; m_rdata = '0; m_rresp = '0; m_rlast = '0; m_rid = '0;
      m_awready = '0; m_wready = '0; m_bvalid = '0; m_bresp = '0; m_bid = '0;
      case (state)
         RD: begin
            s_arvalid      = m_arvalid[gnt] & ~ar_done;
            s_araddr       = m_araddr[gnt];  s_arid   = m_arid[gnt];
            s_arlen        = m_arlen[gnt];   s_arsize = m_arsize[gnt];
            s_arburst      = m_arburst[gnt];
            m_arready[gnt] = s_arready & ~ar_done;
            s_rready       = m_rready[gnt];
            m_rvalid[gnt]  = s_rvalid;       m_rdata[gnt] = s_rdata;
            m_rresp[gnt]   = s_rresp;        m_rlast[gnt] = s_rlast;
            m_rid[gnt]     = s_rid;
         end
         WR: begin
            s_awvalid      = m_awvalid[gnt];
            s_awaddr       = m_awaddr[gnt];  s_awid   = m_awid[gnt];
            s_awlen        = m_awlen[gnt];   s_awsize = m_awsize[gnt];
            s_awburst      = m_awburst[gnt];
            m_awready[gnt] = s_awready;
            s_wvalid       = m_wvalid[gnt];  s_wdata  = m_wdata[gnt];
            s_wstrb        = m_wstrb[gnt];   s_wlast  = m_wlast[gnt];
            m_wready[gnt]  = s_wready;
            s_bready       = m_bready[gnt];
            m_bvalid[gnt]  = s_bvalid;       m_bresp[gnt] = s_bresp;
            m_bid[gnt]     = s_bid;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_ysyx_25040111_axi_arbiter.sv
// Directed bench for the IFU/LSU AXI arbiter; tie order follows YSYX_25040111_ARB_RR_EN.
module tb_ysyx_25040111_axi_arbiter;
   logic clk = 1'b0, rst;
   logic m0_arvalid, m0_arready, m0_rlast, m0_rvalid, m0_rready, m0_awvalid, m0_awready;
   logic m0_wvalid, m0_wlast, m0_wready, m0_bvalid, m0_bready;
   logic [31:0] m0_araddr, m0_rdata, m0_awaddr, m0_wdata;
   logic [3:0] m0_arid, m0_rid, m0_awid, m0_wstrb, m0_bid;
   logic [7:0] m0_arlen, m0_awlen;
   logic [2:0] m0_arsize, m0_awsize;
   logic [1:0] m0_arburst, m0_rresp, m0_awburst, m0_bresp;
   logic m1_arvalid, m1_arready, m1_rlast, m1_rvalid, m1_rready, m1_awvalid, m1_awready;
   logic m1_wvalid, m1_wlast, m1_wready, m1_bvalid, m1_bready;
   logic [31:0] m1_araddr, m1_rdata, m1_awaddr, m1_wdata;
   logic [3:0] m1_arid, m1_rid, m1_awid, m1_wstrb, m1_bid;
   logic [7:0] m1_arlen, m1_awlen;
   logic [2:0] m1_arsize, m1_awsize;
   logic [1:0] m1_arburst, m1_rresp, m1_awburst, m1_bresp;
   logic s_arvalid, s_arready, s_rlast, s_rvalid, s_rready, s_awvalid, s_awready;
   logic s_wvalid, s_wlast, s_wready, s_bvalid, s_bready;
   logic [31:0] s_araddr, s_rdata, s_awaddr, s_wdata;
   logic [3:0] s_arid, s_rid, s_awid, s_wstrb, s_bid;
   logic [7:0] s_arlen, s_awlen;
   logic [2:0] s_arsize, s_awsize;
   logic [1:0] s_arburst, s_rresp, s_awburst, s_bresp;

`ifdef YSYX_25040111_ARB_RR_EN
   localparam int TIE_FIRST = 0;
`else
   localparam int TIE_FIRST = 1;
`endif

   int nchk = 0, nerr = 0;

   ysyx_25040111_axi_arbiter dut (
      .clk(clk), .rst(rst),
      .m0_arvalid(m0_arvalid), .m0_araddr(m0_araddr), .m0_arid(m0_arid), .m0_arlen(m0_arlen),
      .m0_arsize(m0_arsize), .m0_arburst(m0_arburst), .m0_arready(m0_arready),
      .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rlast(m0_rlast), .m0_rid(m0_rid),
      .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
      .m0_awvalid(m0_awvalid), .m0_awaddr(m0_awaddr), .m0_awid(m0_awid), .m0_awlen(m0_awlen),
      .m0_awsize(m0_awsize), .m0_awburst(m0_awburst), .m0_awready(m0_awready),
      .m0_wvalid(m0_wvalid), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wlast(m0_wlast),
      .m0_wready(m0_wready), .m0_bvalid(m0_bvalid), .m0_bresp(m0_bresp), .m0_bid(m0_bid),
      .m0_bready(m0_bready),
      .m1_arvalid(m1_arvalid), .m1_araddr(m1_araddr), .m1_arid(m1_arid), .m1_arlen(m1_arlen),
      .m1_arsize(m1_arsize), .m1_arburst(m1_arburst), .m1_arready(m1_arready),
      .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rlast(m1_rlast), .m1_rid(m1_rid),
      .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
      .m1_awvalid(m1_awvalid), .m1_awaddr(m1_awaddr), .m1_awid(m1_awid), .m1_awlen(m1_awlen),
      .m1_awsize(m1_awsize), .m1_awburst(m1_awburst), .m1_awready(m1_awready),
      .m1_wvalid(m1_wvalid), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wlast(m1_wlast),
      .m1_wready(m1_wready), .m1_bvalid(m1_bvalid), .m1_bresp(m1_bresp), .m1_bid(m1_bid),
      .m1_bready(m1_bready),
      .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arid(s_arid), .s_arlen(s_arlen),
      .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rid(s_rid),
      .s_rvalid(s_rvalid), .s_rready(s_rready),
      .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awid(s_awid), .s_awlen(s_awlen),
      .s_awsize(s_awsize), .s_awburst(s_awburst), .s_awready(s_awready),
      .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
      .s_wready(s_wready), .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bid(s_bid),
      .s_bready(s_bready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // assumes the arbiter is in RD granted to m: complete AR, then one rlast beat
   task automatic rd_xact(input int m, input logic [31:0] d);
      s_arready = 1'b1; #1;
      chk("ar_rdy", m ? m1_arready : m0_arready, 1);
      chk("ar_rdy_other", m ? m0_arready : m1_arready, 0);
      tick();
      s_arready = 1'b0;
      if (m != 0) m1_arvalid = 1'b0; else m0_arvalid = 1'b0;
      s_rvalid = 1'b1; s_rdata = d; s_rlast = 1'b1; s_rresp = 2'b00; #1;
      chk("rvalid", m ? m1_rvalid : m0_rvalid, 1);
      chk("rdata", m ? m1_rdata : m0_rdata, {32'h0, d});
      chk("rresp", m ? m1_rresp : m0_rresp, 0);
      chk("rvalid_other", m ? m0_rvalid : m1_rvalid, 0);
      tick();
      s_rvalid = 1'b0; s_rlast = 1'b0; s_rdata = '0;
   endtask

   task automatic tie_round(input int first);
      m0_arvalid = 1'b1; m0_araddr = 32'h100;
      m1_arvalid = 1'b1; m1_araddr = 32'h200;
      tick();
      chk("tie_first", s_araddr, first ? 32'h200 : 32'h100);
      rd_xact(first, 32'h1111_0000);
      #1 chk("tie_bubble", s_arvalid, 0);
      tick();
      chk("tie_second", s_araddr, first ? 32'h100 : 32'h200);
      rd_xact(1 - first, 32'h2222_0000);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      {m0_arvalid, m0_araddr, m0_arid, m0_arlen, m0_arsize, m0_arburst} = '0;
      {m0_awvalid, m0_awaddr, m0_awid, m0_awlen, m0_awsize, m0_awburst} = '0;
      {m0_wvalid, m0_wdata, m0_wstrb, m0_wlast} = '0;
      {m1_arvalid, m1_araddr, m1_arid, m1_arlen, m1_arsize, m1_arburst} = '0;
      {m1_awvalid, m1_awaddr, m1_awid, m1_awlen, m1_awsize, m1_awburst} = '0;
      {m1_wvalid, m1_wdata, m1_wstrb, m1_wlast} = '0;
      {s_arready, s_rdata, s_rresp, s_rlast, s_rid, s_rvalid, s_awready, s_wready} = '0;
      {s_bvalid, s_bresp, s_bid} = '0;
      m0_rready = 1'b1; m1_rready = 1'b1; m0_bready = 1'b1; m1_bready = 1'b1;

      // reset: everything quiet even with live inputs
      rst = 1'b1;
      m0_arvalid = 1'b1; s_arready = 1'b1; s_rvalid = 1'b1;
      tick(); tick();
      chk("rst_s_arvalid", s_arvalid, 0);
      chk("rst_m0_arready", m0_arready, 0);
      chk("rst_m0_rvalid", m0_rvalid, 0);
      chk("rst_s_rready", s_rready, 0);
      m0_arvalid = 1'b0; s_arready = 1'b0; s_rvalid = 1'b0;
      rst = 1'b0;
      tick();

      // m0 single read
      m0_arvalid = 1'b1; m0_araddr = 32'h3000_0000; m0_arid = 4'h3; #1;
      chk("t1_latency", s_arvalid, 0);
      tick();
      chk("t1_s_arvalid", s_arvalid, 1);
      chk("t1_s_araddr", s_araddr, 32'h3000_0000);
      chk("t1_s_arid", s_arid, 4'h3);
      rd_xact(0, 32'hDEAD_BEEF);
      s_rvalid = 1'b1; s_rlast = 1'b1; #1;
      chk("t1_idle_after", m0_rvalid, 0);
      chk("t1_m1_rvalid", m1_rvalid, 0);
      s_rvalid = 1'b0; s_rlast = 1'b0;
      tick();

      // m1 write
      m1_awvalid = 1'b1; m1_awaddr = 32'h0F00_0004; m1_awid = 4'h5;
      m1_wvalid = 1'b1; m1_wdata = 32'h1234_5678; m1_wstrb = 4'b1100; m1_wlast = 1'b1; #1;
      chk("t2_latency", s_awvalid, 0);
      tick();
      chk("t2_s_awvalid", s_awvalid, 1);
      chk("t2_s_awaddr", s_awaddr, 32'h0F00_0004);
      chk("t2_s_awid", s_awid, 4'h5);
      chk("t2_s_wdata", s_wdata, 32'h1234_5678);
      chk("t2_s_wstrb", s_wstrb, 4'b1100);
      s_awready = 1'b1; s_wready = 1'b1; #1;
      chk("t2_m1_awready", m1_awready, 1);
      chk("t2_m1_wready", m1_wready, 1);
      chk("t2_m0_awready", m0_awready, 0);
      tick();
      m1_awvalid = 1'b0; m1_wvalid = 1'b0; s_awready = 1'b0; s_wready = 1'b0;
      s_bvalid = 1'b1; s_bresp = 2'b00; s_bid = 4'h5; #1;
      chk("t2_m1_bvalid", m1_bvalid, 1);
      chk("t2_m1_bid", m1_bid, 4'h5);
      chk("t2_m0_bvalid", m0_bvalid, 0);
      tick();
      s_bvalid = 1'b0;

      // simultaneous reads out of reset, twice
      rst = 1'b1; tick(); rst = 1'b0;
      tie_round(TIE_FIRST);
      tie_round(TIE_FIRST);

      // m0 burst of 4 with m1 waiting and m0 holding a second AR
      m0_arvalid = 1'b1; m0_araddr = 32'h8000_0000; m0_arlen = 8'd3;
      tick();
      s_arready = 1'b1; #1;
      chk("t4_ar_rdy", m0_arready, 1);
      tick();
      m1_arvalid = 1'b1; m1_araddr = 32'h200;
      for (int b = 0; b < 4; b++) begin
         s_rvalid = 1'b1; s_rdata = 32'hA0 + b; s_rlast = (b == 3); #1;
         chk("t4_rvalid", m0_rvalid, 1);
         chk("t4_rdata", m0_rdata, 32'hA0 + b);
         chk("t4_ar_blocked", s_arvalid, 0);
         chk("t4_m0_arready", m0_arready, 0);
         chk("t4_m1_arready", m1_arready, 0);
         tick();
      end
      s_rvalid = 1'b0; s_rlast = 1'b0; m0_arvalid = 1'b0; s_arready = 1'b0; m0_arlen = '0; #1;
      chk("t4_bubble", s_arvalid, 0);
      chk("t4_bubble_m1", m1_arready, 0);
      tick();
      chk("t4_m1_gnt", s_araddr, 32'h200);
      rd_xact(1, 32'h0BAD_F00D);

      // LSU read and write together: read first, bresp forwarded untouched
      m1_arvalid = 1'b1; m1_araddr = 32'h44;
      m1_awvalid = 1'b1; m1_awaddr = 32'h48; m1_awid = 4'h7;
      m1_wvalid = 1'b1; m1_wdata = 32'hCAFE; m1_wstrb = 4'hF; m1_wlast = 1'b1;
      tick();
      s_awready = 1'b1; s_wready = 1'b1; #1;
      chk("t5_rd_first", s_arvalid, 1);
      chk("t5_no_aw", s_awvalid, 0);
      chk("t5_no_awready", m1_awready, 0);
      rd_xact(1, 32'h55);
      tick();
      chk("t5_s_awvalid", s_awvalid, 1);
      chk("t5_s_awaddr", s_awaddr, 32'h48);
      chk("t5_m1_wready", m1_wready, 1);
      tick();
      m1_awvalid = 1'b0; m1_wvalid = 1'b0; s_awready = 1'b0; s_wready = 1'b0;
      s_bvalid = 1'b1; s_bresp = 2'b10; s_bid = 4'h7; #1;
      chk("t5_m1_bvalid", m1_bvalid, 1);
      chk("t5_m1_bresp", m1_bresp, 2'b10);
      chk("t5_m1_bid", m1_bid, 4'h7);
      tick();
      s_bvalid = 1'b0; s_bresp = 2'b00;

      // reset during beat 2 of a burst
      m0_arvalid = 1'b1; m0_araddr = 32'h9000_0000; m0_arlen = 8'd3;
      tick();
      s_arready = 1'b1;
      tick();
      m0_arvalid = 1'b0; s_arready = 1'b0;
      s_rvalid = 1'b1; s_rdata = 32'h1; #1;
      chk("t6_beat1", m0_rvalid, 1);
      tick();
      s_rdata = 32'h2; #1;
      chk("t6_beat2", m0_rdata, 32'h2);
      rst = 1'b1; #1;
      chk("t6_rst_rvalid", m0_rvalid, 0);
      chk("t6_rst_rdata", m0_rdata, 0);
      chk("t6_rst_rready", s_rready, 0);
      chk("t6_rst_araddr", s_araddr, 0);
      tick();
      s_rvalid = 1'b0; s_rdata = '0; m0_arlen = '0; rst = 1'b0;
      tick();
      tie_round(TIE_FIRST);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
